// File: rtl/riscv_muldiv_unit_if.sv
// rtl/riscv_muldiv_unit_if.sv - request/response bundle for the RV32M multiply/divide unit
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [4:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;

    // Issuing side: the decode/execute stage that presents operations and collects rd.
    modport master (
        output in_valid_i, op_i, rs1_i, rs2_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o
    );

    // Unit side.
    modport slave (
        input  in_valid_i, op_i, rs1_i, rs2_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - iterative RV32M unit: radix-2 shift-add multiplier and restoring divider
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    riscv_muldiv_unit_if.slave    bus
);
    localparam int CW = $clog2(XLEN) + 1;

    // m_func low bits = funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic              neg_q, neg_d;          // negate product / quotient
    logic              sign_a_q, sign_a_d;    // negate remainder
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;          // mul: {hi, multiplier}; div: {rem, quot}
    logic [XLEN-1:0]   opb_q, opb_d;          // mul: multiplicand magnitude; div: divisor magnitude
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b, neg_rs1, neg_rs2;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next, prod_neg, prod_fix;
    logic [XLEN+1:0]   div_trial;
    logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix, final_res;
    logic              is_m_op, div_zero, div_ovf;

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.result_o    = result_q;

    // Operand conditioning, one datapath iteration, and the final sign fixup/select
    always_comb begin
        a_signed  = (bus.op_i[2:0] == F_MULH) || (bus.op_i[2:0] == F_MULHSU) ||
                    (bus.op_i[2:0] == F_DIV)  || (bus.op_i[2:0] == F_REM);
        b_signed  = (bus.op_i[2:0] == F_MULH) || (bus.op_i[2:0] == F_DIV) ||
                    (bus.op_i[2:0] == F_REM);
        sa        = a_signed && bus.rs1_i[XLEN-1];
        sb        = b_signed && bus.rs2_i[XLEN-1];
        neg_rs1   = -bus.rs1_i;
        neg_rs2   = -bus.rs2_i;
        mag_a     = sa ? neg_rs1 : bus.rs1_i;
        mag_b     = sb ? neg_rs2 : bus.rs2_i;
        is_m_op   = (bus.op_i[4:3] == 2'b01);
        div_zero  = bus.op_i[2] && (bus.rs2_i == '0);
        div_ovf   = bus.op_i[2] && !bus.op_i[0] &&
                    (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);

        // Shift-add: add the multiplicand into the high half when the multiplier LSB is set, then shift right.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

        // Restoring step: the shifted partial remainder needs XLEN+1 bits, plus one more for the sign.
        div_trial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
        div_next  = div_trial[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                      : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        prod_neg  = -mul_next;
        prod_fix  = neg_q ? prod_neg : mul_next;
        quot      = div_next[XLEN-1:0];
        rem       = div_next[2*XLEN-1:XLEN];
        quot_fix  = neg_q ? -quot : quot;
        rem_fix   = sign_a_q ? -rem : rem;

        case (func_q)
            F_MUL:                final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:       final_res = quot_fix;
            default:              final_res = rem_fix;
        endcase
    end

    // Next-state logic: accept in IDLE, iterate in CALC, hold the result in DONE
    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    if (!is_m_op) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else if (div_zero) begin
                        result_d = bus.op_i[1] ? bus.rs1_i : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = bus.op_i[1] ? '0 : bus.rs1_i;
                        state_d  = DONE;
                    end else begin
                        func_d   = bus.op_i[2:0];
                        neg_d    = sa ^ sb;
                        sign_a_d = sa;
                        cnt_d    = CW'(XLEN);
                        if (bus.op_i[2]) begin
                            acc_d = {{XLEN{1'b0}}, mag_a};
                            opb_d = mag_b;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, mag_b};
                            opb_d = mag_a;
                        end
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = func_q[2] ? div_next : mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            func_q   <= '0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end
endmodule

// File: doc/riscv_muldiv_unit.md
# riscv_muldiv_unit

Iterative RV32M execution unit: accepts one M-extension operation (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) from the decode/execute stage, computes it over multiple cycles with a radix-2 shift-add multiplier and a restoring divider, and returns the 32-bit rd value. It consumes operation codes in the `m_func` encoding of `riscv_pkg`, i.e. `{instr[30], instr[25], instr[14:12]}`. It sits beside the ALU; the core stalls on `in_ready_o`/`out_valid_o`.

## Interface
- `XLEN`, 32, operand/result width; counter is $clog2(XLEN)+1 bits.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid_i`  in  1  request valid.
- `in_ready_o`  out  1  unit idle, can accept; combinational from state (`state==IDLE`).
- `op_i`  in  5  `riscv_pkg::m_func` code.
- `rs1_i`  in  XLEN  operand A (multiplicand / dividend).
- `rs2_i`  in  XLEN  operand B (multiplier / divisor).
- `out_valid_o`  out  1  result valid, held until accepted.
- `out_ready_i`  in  1  consumer accepts result.
- `result_o`  out  XLEN  rd value, registered, stable while `out_valid_o`.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: accept when `in_valid_i && in_ready_o`; latch op, sign flags, magnitudes.
  - Signedness: A signed for MULH/MULHSU/DIV/REM; B signed for MULH/DIV/REM. MUL result is the low word, so sign handling is irrelevant for it.
  - Signed operands are converted to magnitude (two's-complement negate if MSB set). Result negate flag: mul = signA^signB; div quotient = signA^signB; remainder = signA.
  - Special cases go IDLE->DONE directly, with the result loaded on the accept edge:
    - Divisor==0: DIV/DIVU -> all-ones (0xFFFFFFFF); REM/REMU -> rs1.
    - DIV with rs1=0x80000000, rs2=0xFFFFFFFF: quotient 0x80000000. REM in the same case: 0.
    - `op_i[4:3]!=2'b01` (not an M op): result 0.
  - Otherwise go IDLE->CALC with counter=XLEN.
- CALC: one iteration per cycle; counter decrements; the last iteration occurs when counter==1.
  - Multiply: 2*XLEN product register; add multiplicand when multiplier LSB is 1; shift right.
  - Divide: restoring. Shift {rem,quot} left 1, trial-subtract divisor (XLEN+1-bit), keep if non-negative, and set quot LSB.
  - On the last iteration, apply the sign fixup (2*XLEN-bit negate for mul; XLEN-bit negate for quotient/remainder). Then select: MUL low word, MULH* high word, DIV* quotient, REM* remainder. Register into `result_o` and go to DONE.
- DONE: `out_valid_o=1`; on `out_ready_i` go to IDLE. `result_o` keeps its last value afterwards.
- Inputs are ignored outside IDLE. There is no cancel input. `rst_n` is the only abort.

## Timing
- Reset (rst_n low at an edge): state=IDLE, `out_valid_o`=0, `result_o`=0, internal registers cleared. `in_ready_o`=1 from the first post-reset-edge cycle.
- Reset mid-CALC or mid-DONE: abort at that edge, with no result and no `out_valid_o` pulse. Reset wins over a simultaneous accept or out handshake.
- Normal op latency: accept at edge E0; `out_valid_o` high in the cycle after edge E0+XLEN, i.e. XLEN cycles (32) after the accept edge.
- Special-case latency: `out_valid_o` high in the cycle after the accept edge (1 cycle).
- Earliest `in_ready_o` after accept: the cycle after the out handshake edge. Max throughput is one op per XLEN+2 cycles with `out_ready_i` tied high.
- `out_valid_o` must not drop and `result_o` must not change until the handshake (backpressure of any length).
- `in_ready_o` is low during CALC and DONE. A request presented then must stay pending and be accepted only once the unit is back in IDLE.

## Test plan
- Reset/idle: hold rst_n=0 3 cycles, release.
  - Expect `in_ready_o`=1, `out_valid_o`=0, `result_o`=0.
  - Reset asserted at iteration 10 of a DIV -> no `out_valid_o`, back to IDLE.
- Multiply family, rs1=0xFFFFFFFE (-2), rs2=0x00000003:
  - MUL -> 0xFFFFFFFA.
  - MULH -> 0xFFFFFFFF.
  - MULHSU -> 0xFFFFFFFF.
  - MULHU -> 0x00000002.
  - Each with `out_valid_o` exactly 32 cycles after the accept edge.
- Divide family, rs1=0xFFFFFFF9 (-7), rs2=0x00000002:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU -> 0x7FFFFFFC.
  - REMU -> 0x00000001.
- Special cases, each with 1-cycle latency:
  - DIV x/0 (rs1=0x1234) -> 0xFFFFFFFF.
  - REMU 0x1234/0 -> 0x00001234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
  - op_i=5'b00000 -> 0.
- Handshake:
  - `out_ready_i` low for 20 cycles after `out_valid_o` -> result held stable and `in_ready_o` stays 0.
  - A second request held valid during CALC is accepted only in the cycle after the out handshake.
  - Back-to-back with `out_ready_i`=1 -> period of 34 cycles.
- Random: 10k ops checked against a reference model, with operands biased toward 0, ±1, 0x80000000 and 0xFFFFFFFF.
